// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory-port arbiter of the multicycle core.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  typedef enum logic {
    M0_CORE = 1'b0,
    M1_DBG  = 1'b1
  } owner_t;

  // Width of the wait counter; at least one bit so the register always exists.
  function automatic int cnt_width(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester, response and memory-side signals of the shared memory port.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  import mem_arb_pkg::*;

  logic          req0;
  logic          req1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic          we0;
  logic          we1;
  logic          rsp_valid0;
  logic          rsp_valid1;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          mem_valid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic          mem_ready;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  // Arbiter side.
  modport slave (
    input  req0, req1, addr0, addr1, wdata0, wdata1, we0, we1, mem_ready, mem_rdata,
    output rsp_valid0, rsp_valid1, rsp_rdata, rsp_err, mem_valid, mem_addr, mem_wdata,
           mem_we, busy
  );

  // Requesters plus memory (environment) side.
  modport master (
    output req0, req1, addr0, addr1, wdata0, wdata1, we0, we1, mem_ready, mem_rdata,
    input  rsp_valid0, rsp_valid1, rsp_rdata, rsp_err, mem_valid, mem_addr, mem_wdata,
           mem_we, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between the core (M0) and the
// debug/program loader (M1). One transaction in flight, registered memory-side
// outputs, optional response timeout.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input logic               clk,
  input logic               reset_n,
  mem_port_arbiter_if.slave bus
);

  localparam int               CNT_W   = cnt_width(TIMEOUT);
  localparam bit               TO_EN   = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LIM = TO_EN ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  owner_t           owner_q, owner_d;
  owner_t           last_q, last_d;
  logic             mem_valid_q, mem_valid_d;
  logic [AW-1:0]    mem_addr_q, mem_addr_d;
  logic [DW-1:0]    mem_wdata_q, mem_wdata_d;
  logic             mem_we_q, mem_we_d;
  logic [DW-1:0]    rdata_q, rdata_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic   grant_vld;
  owner_t grant_id;

  // Round-robin pick: a lone requester wins; on a tie the one not granted last wins.
  always_comb begin
    grant_vld = bus.req0 | bus.req1;
    if (bus.req0 && bus.req1) begin
      grant_id = (last_q == M0_CORE) ? M1_DBG : M0_CORE;
    end else if (bus.req1) begin
      grant_id = M1_DBG;
    end else begin
      grant_id = M0_CORE;
    end
  end

  // Next-state logic: grant in IDLE, wait for ready or timeout in ISSUE, one response cycle.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = mem_we_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (grant_vld) begin
          state_d     = ISSUE;
          owner_d     = grant_id;
          last_d      = grant_id;
          mem_valid_d = 1'b1;
          cnt_d       = '0;
          mem_addr_d  = (grant_id == M1_DBG) ? bus.addr1  : bus.addr0;
          mem_wdata_d = (grant_id == M1_DBG) ? bus.wdata1 : bus.wdata0;
          mem_we_d    = (grant_id == M1_DBG) ? bus.we1    : bus.we0;
        end
      end
      ISSUE: begin
        // A ready arriving on the limit cycle still completes normally.
        if (bus.mem_ready) begin
          rdata_d     = mem_we_q ? '0 : bus.mem_rdata;
          err_d       = 1'b0;
          mem_valid_d = 1'b0;
          state_d     = RESP;
        end else if (TO_EN && (cnt_q == CNT_LIM)) begin
          rdata_d     = '0;
          err_d       = 1'b1;
          mem_valid_d = 1'b0;
          state_d     = RESP;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d     = IDLE;
        mem_valid_d = 1'b0;
      end
    endcase
  end

  // State and latched outputs; reset aborts any transaction and drops mem_valid at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      owner_q     <= M0_CORE;
      last_q      <= M1_DBG;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.rsp_valid0 = (state_q == RESP) && (owner_q == M0_CORE);
  assign bus.rsp_valid1 = (state_q == RESP) && (owner_q == M1_DBG);
  assign bus.rsp_rdata  = rdata_q;
  assign bus.rsp_err    = err_q;
  assign bus.mem_valid  = mem_valid_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: random and directed traffic, scoreboard of expected responses.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) ifa ();
  mem_port_arbiter_if #(.AW(AW), .DW(DW)) ifb ();

  mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut_a (.clk(clk), .reset_n(rst_n), .bus(ifa));
  mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(0))  dut_b (.clk(clk), .reset_n(rst_n), .bus(ifb));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard entries: which port must answer, with what, and on which cycle.
  typedef struct {
    bit          port;
    logic [31:0] data;
    bit          err;
    int          due;
  } exp_t;
  exp_t sbq[$];

  // Requester model state.
  bit          act[2];
  int          cont[2];
  logic [31:0] r_addr[2];
  logic [31:0] r_wdata[2];
  bit          r_we[2];
  bit          rand_en = 1'b0;

  // Memory / scoreboard controls and observations.
  int          force_w = -1;
  bit          force_d_en = 1'b0;
  logic [31:0] force_d = '0;
  int          first_mv_cyc = 0;
  int          last_rsp_cyc = 0;
  bit          last_err = 1'b0;
  bit          rsp_log[$];
  int          rsp_total = 0;

  task automatic drive_req();
    ifa.req0   = act[0];
    ifa.req1   = act[1];
    ifa.addr0  = r_addr[0];
    ifa.addr1  = r_addr[1];
    ifa.wdata0 = r_wdata[0];
    ifa.wdata1 = r_wdata[1];
    ifa.we0    = r_we[0];
    ifa.we1    = r_we[1];
  endtask

  task automatic new_tx(input int m, input logic [31:0] a, input logic [31:0] d, input bit we);
    act[m]     = 1'b1;
    r_addr[m]  = a;
    r_wdata[m] = d;
    r_we[m]    = we;
    drive_req();
  endtask

  task automatic new_rand_tx(input int m);
    logic [31:0] a;
    a = $urandom & 32'hFFFF_FFFC;
    new_tx(m, a, $urandom, 1'($urandom_range(0, 1)));
  endtask

  // Requester behaviour, run once per cycle just after the clock edge.
  task automatic step();
    bit rv[2];
    rv[0] = ifa.rsp_valid0;
    rv[1] = ifa.rsp_valid1;
    for (int m = 0; m < 2; m++) begin
      if (act[m] && rv[m]) begin
        act[m] = 1'b0;
        if (cont[m] > 0) begin
          cont[m]--;
          new_rand_tx(m);
        end
      end
    end
    if (rand_en) begin
      for (int m = 0; m < 2; m++) begin
        if (!act[m] && ($urandom_range(0, 3) == 0)) new_rand_tx(m);
      end
    end
    drive_req();
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      step();
    end
  endtask

  task automatic wait_rsp(input int target, input int budget);
    int i;
    i = 0;
    while (rsp_total < target && i < budget) begin
      tick(1);
      i++;
    end
    chk("rsp_arrived", rsp_total, target);
  endtask

  task automatic wait_mv(input int budget);
    int i;
    i = 0;
    while (!ifa.mem_valid && i < budget) begin
      tick(1);
      i++;
    end
    chk("mem_valid_seen", ifa.mem_valid, 1);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    for (int m = 0; m < 2; m++) begin
      act[m]  = 1'b0;
      cont[m] = 0;
    end
    drive_req();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Memory responder and grant checker: picks a wait count per transaction,
  // predicts the arbitration winner and queues the expected response.
  initial begin
    bit          last_g;
    bit          in_txn;
    bit          owner;
    bit          pr0, pr1, timed;
    int          w, k, start, ncyc;
    logic [31:0] rword;
    last_g = 1'b1; in_txn = 1'b0; owner = 1'b0; pr0 = 1'b0; pr1 = 1'b0;
    w = 0; k = 0; start = 0; ncyc = 0; rword = '0;
    ifa.mem_ready = 1'b0;
    ifa.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_txn = 1'b0; last_g = 1'b1; pr0 = 1'b0; pr1 = 1'b0;
        ifa.mem_ready = 1'b0;
      end else begin
        chk("busy_vs_activity", ifa.busy, ifa.mem_valid | ifa.rsp_valid0 | ifa.rsp_valid1);
        if (ifa.rsp_valid0 && ifa.rsp_valid1) chk("rsp_exclusive", 1, 0);
        if (ifa.mem_valid) begin
          if (!in_txn) begin
            chk("grant_had_req", pr0 | pr1, 1);
            owner  = (pr0 && pr1) ? !last_g : pr1;
            last_g = owner;
            w      = (force_w >= 0) ? force_w : $urandom_range(0, 5);
            rword  = force_d_en ? force_d : $urandom;
            timed  = (w >= TO);
            ncyc   = timed ? TO : w + 1;
            start  = cyc;
            k      = 0;
            in_txn = 1'b1;
            first_mv_cyc = cyc;
            sbq.push_back('{port: owner, data: (timed || r_we[owner]) ? 32'h0 : rword,
                            err: timed, due: cyc + ncyc});
          end
          chk("mem_addr", ifa.mem_addr, r_addr[owner]);
          chk("mem_wdata", ifa.mem_wdata, r_wdata[owner]);
          chk("mem_we", ifa.mem_we, r_we[owner]);
          chk("mem_valid_len_ok", (cyc - start) < ncyc, 1);
          ifa.mem_ready = (k == w);
          ifa.mem_rdata = (k == w) ? rword : $urandom;
          k++;
        end else begin
          in_txn = 1'b0;
          ifa.mem_ready = 1'b0;
          ifa.mem_rdata = $urandom;
        end
        pr0 = ifa.req0;
        pr1 = ifa.req1;
      end
    end
  end

  // Response monitor: pops the scoreboard whenever a response pulse appears.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sbq.delete();
      end else if (ifa.rsp_valid0 || ifa.rsp_valid1) begin
        rsp_log.push_back(ifa.rsp_valid1);
        rsp_total++;
        last_rsp_cyc = cyc;
        last_err = ifa.rsp_err;
        if (sbq.size() == 0) begin
          chk("unexpected_rsp", 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("rsp_port", ifa.rsp_valid1, e.port);
          chk("rsp_rdata", ifa.rsp_rdata, e.data);
          chk("rsp_err", ifa.rsp_err, e.err);
          chk("rsp_cycle", cyc, e.due);
          chk("mem_valid_off_in_rsp", ifa.mem_valid, 0);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, base, mv, got, bad, r0;
    for (int m = 0; m < 2; m++) begin
      act[m] = 1'b0; cont[m] = 0; r_addr[m] = '0; r_wdata[m] = '0; r_we[m] = 1'b0;
    end
    drive_req();
    ifb.req0 = 1'b0; ifb.req1 = 1'b0; ifb.addr0 = '0; ifb.addr1 = '0;
    ifb.wdata0 = '0; ifb.wdata1 = '0; ifb.we0 = 1'b0; ifb.we1 = 1'b0;
    ifb.mem_ready = 1'b0; ifb.mem_rdata = '0;

    // Reset state.
    #1;
    chk("rst_flags", {ifa.mem_valid, ifa.busy, ifa.rsp_valid0, ifa.rsp_valid1, ifa.rsp_err,
                      ifa.mem_we}, 6'b0);
    chk("rst_mem_addr", ifa.mem_addr, 0);
    chk("rst_mem_wdata", ifa.mem_wdata, 0);
    chk("rst_rsp_rdata", ifa.rsp_rdata, 0);
    reset_dut();
    tick(2);

    // Single zero-wait read.
    force_w = 0; force_d_en = 1'b1; force_d = 32'hDEAD_BEEF;
    base = rsp_total;
    n = cyc;
    new_tx(0, 32'h100, 32'h0, 1'b0);
    wait_rsp(base + 1, 20);
    chk("t1_mv_cycle", first_mv_cyc, n + 1);
    chk("t1_rsp_cycle", last_rsp_cyc, n + 2);
    force_d_en = 1'b0;

    // Tie right after reset with both held: M0, M1, M0, M1.
    reset_dut();
    tick(1);
    force_w = 1;
    base = rsp_total;
    cont[0] = 1; cont[1] = 1;
    new_rand_tx(0);
    new_rand_tx(1);
    wait_rsp(base + 4, 60);
    if (rsp_log.size() >= base + 4) begin
      for (int i = 0; i < 4; i++) chk("t2_alternation", rsp_log[base + i], i % 2);
    end
    tick(2);

    // Timeout with no ready, then ready on the limit cycle.
    force_w = 99;
    base = rsp_total;
    new_tx(0, 32'h300, 32'h1111_2222, 1'b0);
    wait_rsp(base + 1, 30);
    chk("t4_mv_len_timeout", last_rsp_cyc - first_mv_cyc, TO);
    chk("t4_err_set", last_err, 1);
    force_w = TO - 1;
    new_tx(0, 32'h304, 32'h0, 1'b0);
    wait_rsp(base + 2, 30);
    chk("t4_mv_len_limit_ready", last_rsp_cyc - first_mv_cyc, TO);
    chk("t4_err_clear", last_err, 0);
    tick(1);

    // M1 request arriving while M0 is in ISSUE is served next.
    force_w = 2;
    base = rsp_total;
    new_tx(0, 32'h400, 32'h0, 1'b0);
    wait_mv(10);
    new_tx(1, 32'h500, 32'hABCD_0001, 1'b1);
    wait_rsp(base + 2, 40);
    if (rsp_log.size() >= base + 2) begin
      chk("t5_first_m0", rsp_log[base], 0);
      chk("t5_then_m1", rsp_log[base + 1], 1);
    end
    tick(2);

    // Reset in the middle of ISSUE.
    force_w = 99;
    new_tx(0, 32'h600, 32'h0, 1'b0);
    wait_mv(10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_mv_async_drop", ifa.mem_valid, 0);
    chk("t6_busy_async_drop", ifa.busy, 0);
    for (int m = 0; m < 2; m++) begin
      act[m] = 1'b0; cont[m] = 0;
    end
    drive_req();
    base = rsp_total;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(3);
    chk("t6_no_rsp", rsp_total, base);
    force_w = 0;
    new_rand_tx(0);
    new_rand_tx(1);
    wait_rsp(base + 2, 30);
    if (rsp_log.size() >= base + 2) begin
      chk("t6_tie_m0_first", rsp_log[base], 0);
      chk("t6_tie_m1_second", rsp_log[base + 1], 1);
    end
    tick(2);

    // Random traffic including timeouts.
    force_w = -1;
    rand_en = 1'b1;
    tick(2500);
    rand_en = 1'b0;
    for (int i = 0; i < 200 && (act[0] || act[1]); i++) tick(1);
    chk("drain_idle", {act[0], act[1]}, 2'b00);
    tick(2);
    chk("scoreboard_empty", sbq.size(), 0);

    // Wait states on the no-timeout instance: M1 write, ready on the sixth cycle.
    @(posedge clk);
    #1;
    ifb.addr1 = 32'h200; ifb.wdata1 = 32'hCAFE_F00D; ifb.we1 = 1'b1;
    ifb.mem_rdata = 32'h1234_5678;
    ifb.req1 = 1'b1;
    mv = 0; got = 0; bad = 0; r0 = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ifb.mem_valid) begin
        mv++;
        if (ifb.mem_addr !== 32'h200 || ifb.mem_wdata !== 32'hCAFE_F00D || ifb.mem_we !== 1'b1)
          bad++;
        ifb.mem_ready = (mv == 6);
      end else begin
        ifb.mem_ready = 1'b0;
      end
      if (ifb.rsp_valid0) r0++;
      if (ifb.rsp_valid1) begin
        got++;
        chk("t3_rsp_rdata", ifb.rsp_rdata, 0);
        chk("t3_rsp_err", ifb.rsp_err, 0);
        ifb.req1 = 1'b0;
      end
    end
    chk("t3_mv_cycles", mv, 6);
    chk("t3_rsp_count", got, 1);
    chk("t3_fields_stable", bad, 0);
    chk("t3_no_rsp0", r0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
